// File: rtl/dnn_mac_seq.sv
// Two-layer dense network (ReLU hidden, optional ReLU output) on one shared signed MAC.
// Latency: out_valid rises N_IN*N_HID + N_HID*N_OUT edges after the accepting edge.
// Backpressure: results held in DONE until out_ready; in_ready only while IDLE.
module dnn_mac_seq #(
  parameter int DW    = 5,
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int OW    = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DW-1:0]       x,
  input  logic [N_IN*N_HID*DW-1:0] w1,
  input  logic [N_HID*N_OUT*DW-1:0] w2,
  input  logic                     relu_out,
  output logic [N_OUT*OW-1:0]      out,
  output logic [N_OUT-1:0]         out_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  // Hidden values, single product and accumulator widths keep all sums exact.
  localparam int HW = 2*DW + $clog2(N_IN);
  localparam int PW = HW + DW;
  localparam int AW = PW + $clog2(N_HID);
  localparam int CW = ((AW > OW) ? AW : OW) + 1;
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

  localparam logic signed [CW-1:0] SMAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] SMIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state, state_nxt;

  logic [N_IN*DW-1:0]        x_r;
  logic [N_IN*N_HID*DW-1:0]  w1_r;
  logic [N_HID*N_OUT*DW-1:0] w2_r;
  logic                      relu_r;
  logic [IW-1:0]             i_cnt;
  logic [JW-1:0]             j_cnt;
  logic [KW-1:0]             k_cnt;
  logic signed [AW-1:0]      acc;
  logic signed [HW-1:0]      hid [N_HID];
  logic [N_OUT*OW-1:0]       out_r;
  logic [N_OUT-1:0]          sat_r;

  logic signed [HW-1:0] op_a;
  logic signed [DW-1:0] op_b;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] r_val;
  logic signed [CW-1:0] r_ext;
  logic signed [HW-1:0] h_val;
  logic [OW-1:0]        sat_val;
  logic                 over, under;
  logic                 i_last, j_last, k_last;

  assign i_last    = (i_cnt == I_LAST);
  assign j_last    = (j_cnt == J_LAST);
  assign k_last    = (k_cnt == K_LAST);
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE) && !rst;
  assign busy      = (state != IDLE);
  assign out       = out_r;
  assign out_sat   = sat_r;

  // Operand select for the shared MAC, running sum, ReLU and output saturation.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == L2) begin
      op_a = hid[j_cnt];
      op_b = w2_r[(int'(k_cnt)*N_HID + int'(j_cnt))*DW +: DW];
    end else begin
      op_a = HW'($signed(x_r[int'(i_cnt)*DW +: DW]));
      op_b = w1_r[(int'(j_cnt)*N_IN + int'(i_cnt))*DW +: DW];
    end
    prod    = PW'(op_a) * PW'(op_b);
    sum     = acc + AW'(prod);
    h_val   = sum[AW-1] ? '0 : sum[HW-1:0];
    r_val   = (relu_r && sum[AW-1]) ? '0 : sum;
    r_ext   = CW'(r_val);
    over    = (r_ext > SMAX);
    under   = (r_ext < SMIN);
    sat_val = over ? SMAX[OW-1:0] : (under ? SMIN[OW-1:0] : r_ext[OW-1:0]);
  end

  // Next-state logic: last product of each layer advances the phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)         state_nxt = L1;
      L1:   if (i_last && j_last) state_nxt = L2;
      L2:   if (j_last && k_last) state_nxt = DONE;
      DONE: if (out_ready)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, accumulation, hidden/output write-back and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r    <= '0;
      w1_r   <= '0;
      w2_r   <= '0;
      relu_r <= 1'b0;
      i_cnt  <= '0;
      j_cnt  <= '0;
      k_cnt  <= '0;
      acc    <= '0;
      out_r  <= '0;
      sat_r  <= '0;
      for (int n = 0; n < N_HID; n++) hid[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x;
            w1_r   <= w1;
            w2_r   <= w2;
            relu_r <= relu_out;
            acc    <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
          end
        end
        L1: begin
          if (i_last) begin
            hid[j_cnt] <= h_val;
            acc        <= '0;
            i_cnt      <= '0;
            j_cnt      <= j_last ? '0 : j_cnt + JW'(1);
          end else begin
            acc   <= sum;
            i_cnt <= i_cnt + IW'(1);
          end
        end
        L2: begin
          if (j_last) begin
            out_r[int'(k_cnt)*OW +: OW] <= sat_val;
            sat_r[k_cnt]                <= over | under;
            acc                         <= '0;
            j_cnt                       <= '0;
            k_cnt                       <= k_last ? '0 : k_cnt + KW'(1);
          end else begin
            acc   <= sum;
            j_cnt <= j_cnt + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_mac_seq.sv
// Directed bench for dnn_mac_seq at defaults plus a parallel OW=15 instance.
// Checks reset values, latency, results, saturation, backpressure and mid-job reset.
module tb_dnn_mac_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, relu_out;
  logic [19:0] x;
  logic [79:0] w1;
  logic [39:0] w2;
  logic        in_ready, out_valid, busy;
  logic [33:0] out;
  logic [1:0]  out_sat;
  logic        in_ready15, out_valid15, busy15;
  logic [29:0] out15;
  logic [1:0]  out_sat15;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  dnn_mac_seq u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w1(w1), .w2(w2), .relu_out(relu_out),
    .out(out), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  dnn_mac_seq #(.OW(15)) u_dut15 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready15),
    .x(x), .w1(w1), .w2(w2), .relu_out(relu_out),
    .out(out15), .out_sat(out_sat15), .out_valid(out_valid15),
    .out_ready(out_ready), .busy(busy15)
  );

  function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  function automatic logic signed [63:0] sx(input logic [16:0] v, input int w);
    logic signed [63:0] r;
    r = 64'(v);
    if (v[w-1]) r = r - (64'sd1 <<< w);
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stim1(input logic relu);
    x  = p4(4, 2, 4, 1);
    w1 = {p4(9, -10, 15, -10), p4(3, 6, -15, 15), p4(-9, 1, -4, 14), p4(3, 2, 13, -6)};
    w2 = {p4(-12, -15, -15, 6), p4(0, -1, 3, -11)};
    relu_out = relu;
  endtask

  task automatic scramble();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    x  = t[19:0];
    w1 = t[99:20];
    w2 = t[127:88];
    relu_out = t[0];
  endtask

  // Present one bundle while IDLE; the next rising edge accepts it.
  task automatic accept(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    check({tag, "_busy"}, 64'(busy), 1);
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; relu_out = 1'b0;
    x = '0; w1 = '0; w2 = '0;

    // Reset values
    @(negedge clk);
    check("rst_in_ready_low", 64'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_out", 64'(out), 0);
    check("rst_out_sat", 64'(out_sat), 0);

    // Mixed signs, relu_out=0, consumer not ready
    stim1(1'b0);
    accept("j1");
    wait_out(lat);
    check("j1_latency", lat, 24);
    check("j1_out0", sx(out[16:0], 17), -726);
    check("j1_out1", sx(out[33:17], 17), -348);
    check("j1_sat", 64'(out_sat), 0);
    check("j1_ow15_out0", sx({2'b00, out15[14:0]}, 15), -726);
    check("j1_ow15_sat", 64'(out_sat15), 0);

    // Backpressure: results held, pending bundle not taken
    stim1(1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 1);
      check("bp_in_ready", 64'(in_ready), 0);
      check("bp_out0", sx(out[16:0], 17), -726);
      check("bp_out1", sx(out[33:17], 17), -348);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_out_valid", 64'(out_valid), 0);
    check("hs_in_ready", 64'(in_ready), 1);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    check("j2_busy", 64'(busy), 1);
    wait_out(lat);
    check("j2_latency", lat, 24);
    check("j2_relu_out0", sx(out[16:0], 17), 0);
    check("j2_relu_out1", sx(out[33:17], 17), 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("j2_released", 64'(busy), 0);

    // All operands -16: exact minimum at OW=17, clipped at OW=15
    x = {4{5'h10}}; w1 = {16{5'h10}}; w2 = {8{5'h10}}; relu_out = 1'b0;
    accept("j3");
    wait_out(lat);
    check("j3_latency", lat, 24);
    check("j3_out0", sx(out[16:0], 17), -65536);
    check("j3_out1", sx(out[33:17], 17), -65536);
    check("j3_sat", 64'(out_sat), 0);
    check("j3_ow15_out0", sx({2'b00, out15[14:0]}, 15), -16384);
    check("j3_ow15_out1", sx({2'b00, out15[29:15]}, 15), -16384);
    check("j3_ow15_sat", 64'(out_sat15), 3);
    @(negedge clk);
    check("j3_done_one_cycle", 64'(out_valid), 0);
    check("j3_idle_in_ready", 64'(in_ready), 1);

    // All operands 15: 54000 at OW=17, saturated to 16383 at OW=15
    x = {4{5'h0f}}; w1 = {16{5'h0f}}; w2 = {8{5'h0f}}; relu_out = 1'b1;
    accept("j4");
    wait_out(lat);
    check("j4_latency", lat, 24);
    check("j4_out0", sx(out[16:0], 17), 54000);
    check("j4_out1", sx(out[33:17], 17), 54000);
    check("j4_sat", 64'(out_sat), 0);
    check("j4_ow15_out0", sx({2'b00, out15[14:0]}, 15), 16383);
    check("j4_ow15_out1", sx({2'b00, out15[29:15]}, 15), 16383);
    check("j4_ow15_sat", 64'(out_sat15), 3);
    @(negedge clk);

    // Reset during L2 abandons the job
    stim1(1'b0);
    accept("j5");
    repeat (19) @(negedge clk);
    check("j5_busy_l2", 64'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("j5_rst_out_valid", 64'(out_valid), 0);
    check("j5_rst_busy", 64'(busy), 0);
    check("j5_rst_out", 64'(out), 0);
    check("j5_rst_sat", 64'(out_sat), 0);
    check("j5_rst_in_ready", 64'(in_ready), 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("j5_no_out_valid", seen, 0);

    // Job after reset runs at nominal latency
    stim1(1'b0);
    accept("j6");
    wait_out(lat);
    check("j6_latency", lat, 24);
    check("j6_out0", sx(out[16:0], 17), -726);
    check("j6_out1", sx(out[33:17], 17), -348);
    check("j6_sat", 64'(out_sat), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
